// File: rtl/board_writer.sv
// Tic-tac-toe board writer: accepts moves, tracks X/O boards, detects game end.
// Optional line evaluation is compiled in with the WIN_DETECT_EN macro.
module board_writer #(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       counter_reset,
    input  logic [3:0] current_slot,
    input  logic       place,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic       player,
    output logic       place_ack,
    output logic       place_err,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {READY, CHECK, DONE} state_t;

    state_t     state_q, state_d;
    logic [8:0] bx_q, bx_d, bo_q, bo_d;
    logic       player_q, player_d;
    logic       ack_q, ack_d, err_q, err_d;
    logic       go_q, go_d;
    logic [1:0] win_q, win_d;

    logic [15:0] slot_dec;
    logic [8:0]  slot_mask;
    logic        slot_ok;
    logic        mover_wins;

    // Out-of-range slots decode to an all-zero mask and are rejected.
    assign slot_dec  = 16'h0001 << current_slot;
    assign slot_mask = slot_dec[8:0];
    assign slot_ok   = (current_slot <= 4'd8) && !(|(slot_mask & (bx_q | bo_q)));

`ifdef WIN_DETECT_EN
    function automatic logic has_line(input logic [8:0] b);
        return (&b[8:6]) | (&b[5:3]) | (&b[2:0]) |
               (b[8] & b[5] & b[2]) | (b[7] & b[4] & b[1]) | (b[6] & b[3] & b[0]) |
               (b[8] & b[4] & b[0]) | (b[6] & b[4] & b[2]);
    endfunction

    // player_q has already toggled in CHECK, so 1 means X made the last move.
    assign mover_wins = has_line(player_q ? bx_q : bo_q);
`else
    assign mover_wins = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        bx_d     = bx_q;
        bo_d     = bo_q;
        player_d = player_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        go_d     = go_q;
        win_d    = win_q;
        case (state_q)
            READY: begin
                if (place) begin
                    if (slot_ok) begin
                        if (player_q) bo_d = bo_q | slot_mask;
                        else          bx_d = bx_q | slot_mask;
                        player_d = ~player_q;
                        ack_d    = 1'b1;
                        state_d  = CHECK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                err_d = place;
                // A win on the ninth mark takes priority over the draw.
                if (mover_wins) begin
                    win_d   = player_q ? 2'b01 : 2'b10;
                    go_d    = 1'b1;
                    state_d = DONE;
                end else if (&(bx_q | bo_q)) begin
                    win_d   = 2'b11;
                    go_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = READY;
                end
            end
            DONE:    err_d   = place;
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk or posedge counter_reset) begin
        if (counter_reset) begin
            state_q  <= READY;
            bx_q     <= '0;
            bo_q     <= '0;
            player_q <= FIRST_PLAYER;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            go_q     <= 1'b0;
            win_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            bx_q     <= bx_d;
            bo_q     <= bo_d;
            player_q <= player_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            go_q     <= go_d;
            win_q    <= win_d;
        end
    end

    assign board_x   = bx_q;
    assign board_o   = bo_q;
    assign player    = player_q;
    assign place_ack = ack_q;
    assign place_err = err_q;
    assign game_over = go_q;
    assign winner    = win_q;

endmodule
